elbeth_muldiv: RTL

- Iterative multiply/divide unit for the ELBETH datapath; the sequential responder that sits beside elbeth_alu and takes the operations the single-cycle ALU cannot do.
- Accepts two WIDTH-bit operands and an opcode over a valid/ready request channel.
- Iterates one bit per clock, then presents a HI/LO result pair on a valid/ready response channel held until consumed.

---
 rtl/elbeth_muldiv_if.sv | 25 ++
 rtl/elbeth_muldiv.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/elbeth_muldiv_if.sv
// rtl/elbeth_muldiv_if.sv - request/response bundle between the ELBETH datapath and the mul/div unit
interface elbeth_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             div_by_zero;

   modport master (
      output req_valid, op, data_a, data_b, resp_ready,
      input  req_ready, resp_valid, result_hi, result_lo, div_by_zero
   );

   modport slave (
      input  req_valid, op, data_a, data_b, resp_ready,
      output req_ready, resp_valid, result_hi, result_lo, div_by_zero
   );
endinterface

// File: rtl/elbeth_muldiv.sv
// rtl/elbeth_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per clock
// Optional macro MULDIV_EARLY_EXIT_EN: a zero data_b skips the iterations (response one edge after accept).
module elbeth_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   elbeth_muldiv_if.slave     bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] a_raw_q, a_raw_d;
   logic             bzero_q, bzero_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic             dbz_q, dbz_d;

   logic             a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod, prod_neg;

   // Signed ops work on magnitudes; the signs are re-applied once at the end.
   assign a_neg  = bus.op[0] & bus.data_a[WIDTH-1];
   assign b_neg  = bus.op[0] & bus.data_b[WIDTH-1];
   assign a_mag  = a_neg ? -bus.data_a : bus.data_a;
   assign b_mag  = b_neg ? -bus.data_b : bus.data_b;
   assign b_zero = (bus.data_b == '0);

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand_q});
   // Only the low bits matter: when div_ge holds the difference is below the divisor.
   assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;
   assign prod      = {hi_q, lo_q};
   assign prod_neg  = -prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         a_raw_q   <= '0;
         bzero_q   <= 1'b0;
         res_hi_q  <= '0;
         res_lo_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         a_raw_q   <= a_raw_d;
         bzero_q   <= bzero_d;
         res_hi_q  <= res_hi_d;
         res_lo_q  <= res_lo_d;
         dbz_q     <= dbz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      a_raw_d   = a_raw_q;
      bzero_d   = bzero_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      dbz_d     = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d   = S_CALC;
               cnt_d     = '0;
               is_div_d  = bus.op[1];
               hi_d      = '0;
               lo_d      = bus.op[1] ? a_mag : b_mag;
               mcand_d   = bus.op[1] ? b_mag : a_mag;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               a_raw_d   = bus.data_a;
               bzero_d   = b_zero;
               dbz_d     = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
               // Jump straight to the final step; a zero multiplier leaves the product at 0.
               if (b_zero) cnt_d = CW'(WIDTH);
`endif
            end
         end
         S_CALC: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = S_DONE;
               if (is_div_q) begin
                  if (bzero_q) begin
                     res_lo_d = '1;
                     res_hi_d = a_raw_q;
                     dbz_d    = 1'b1;
                  end else begin
                     res_lo_d = neg_res_q ? -lo_q : lo_q;
                     res_hi_d = neg_rem_q ? -hi_q : hi_q;
                  end
               end else begin
                  {res_hi_d, res_lo_d} = neg_res_q ? prod_neg : prod;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (is_div_q) begin
                  hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], div_ge};
               end else begin
                  {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
               end
            end
         end
         S_DONE: begin
            if (bus.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.resp_valid  = (state_q == S_DONE);
   assign bus.result_hi   = res_hi_q;
   assign bus.result_lo   = res_lo_q;
   assign bus.div_by_zero = dbz_q;
endmodule
